pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised successor of the fixed 64-bit IF/ID stage register. It carries a generic DATA_W payload between pipeline stages using a valid/ready handshake and a 2-entry skid, so backpressure from the next stage never drops an instruction. Freeze (hazard stall) and flush (branch taken) behave as in the existing stage registers. A saturating counter reports how many valid entries flushes have discarded. It is instantiated once per stage boundary: IF/ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
DATA_W, 64, payload width in bits ({PC, Instruction} for IF/ID)
FLUSH_VAL, {DATA_W{1'b0}}, value loaded into both data registers on reset and flush
CNT_W, 8, width of the discarded-entry counter

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
freeze  in  1  hazard stall; holds all state
flush  in  1  discard contents; priority over freeze
in_valid  in  1  upstream payload valid
in_data  in  DATA_W  upstream payload
in_ready  out  1  stage can accept this cycle
out_valid  out  1  payload presented downstream
out_data  out  DATA_W  payload to next stage
out_ready  in  1  downstream accepts
occupancy  out  2  entries held: 0, 1 or 2
drop_cnt  out  CNT_W  saturating count of valid entries discarded by flush

Behaviour:
- State: main register (m_valid, m_data) and skid register (s_valid, s_data).
- Reset: clk is the only clock. rst is synchronous and active-high, sampled at the posedge of clk.
- Reset values: m_valid=0, s_valid=0, m_data=s_data=FLUSH_VAL, drop_cnt=0.
- Priority each posedge: rst > flush > freeze > normal operation.
- Combinational outputs:
  - in_ready = ~s_valid & ~freeze & ~flush
  - out_valid = m_valid & ~freeze
  - out_data = m_data
  - occupancy = m_valid + s_valid
- Handshake events:
  - acc = in_valid & in_ready
  - fire = out_valid & out_ready
- Flush cycle:
  - Next state: m_valid=0, s_valid=0, m_data=s_data=FLUSH_VAL.
  - in_data is ignored and in_ready=0 in that cycle.
  - drop_cnt += m_valid + s_valid, saturating at 2^CNT_W-1.
  - Flush while frozen still clears.
- Freeze (no flush): every register holds. in_ready=0 and out_valid=0, so no transfer occurs.
- Normal operation (no flush, no freeze):
  - Main empty or fire: main loads from skid if s_valid, else from input if acc, else m_valid goes to 0 (m_data holds).
  - Loading from skid with acc: the input goes to skid, keeping s_valid=1.
  - Loading from skid without acc: s_valid goes to 0.
  - Main full, no fire, and acc: the input goes to skid (s_valid=1).
  - Main full, no fire, no acc: hold.
- Ordering: FIFO order is always preserved, and an entry is never duplicated or lost except by flush.
- Latency: one cycle from acc to out_valid when main is empty or firing. Throughput is 1 per cycle with out_ready held high.
- Skid full: in_ready deasserts the same cycle s_valid=1. It reasserts the cycle after the fire that drains the skid into main.
- Simultaneous flush and acc: the input is dropped and not counted (it was never accepted, since in_ready=0).
- Reset mid-operation: clears everything, including drop_cnt. Outputs are valid-low from the next cycle.
- Invariant: s_valid=1 implies m_valid=1.

Decomposition:
- Shared package pipe_pkg holds:
  - per-stage width constants IF_ID_W=64, ID_EX_W, EX_MEM_W, MEM_WB_W
  - the default FLUSH_VAL per stage
- One natural sub-module, sat_counter (parameter CNT_W; inputs clear and a 2-bit increment), for drop_cnt.
- The skid logic stays inline.

Test Plan:
- Streaming: out_ready=1, in_valid=1, in_data=0x1, 0x2, 0x3 on consecutive cycles -> out_data 0x1, 0x2, 0x3 one cycle later each, out_valid continuous, occupancy=1.
- Backpressure: out_ready=0, push 0xA then 0xB -> occupancy=2, in_ready=0, 0xC held off. Then out_ready=1 -> out 0xA, 0xB, 0xC in order, no loss.
- Flush: occupancy=2, flush=1 for one cycle -> next cycle out_valid=0, occupancy=0, out_data=FLUSH_VAL, drop_cnt=2.
- Freeze: main holds 0x55, freeze=1 for 3 cycles with out_ready=1 and in_valid=1 -> out_valid=0, in_ready=0, occupancy unchanged. After release, 0x55 emitted first.
- Flush+freeze+acc: freeze=1, flush=1, in_valid=1, one entry held -> cleared, drop_cnt+=1, input not accepted. drop_cnt at 2^CNT_W-1 plus another flush -> stays saturated.
- Reset mid-stream: rst=1 for one cycle with occupancy=2 and drop_cnt=5 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary widths and flush values.
// Stage registers import this to size their payloads.
package pipe_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = 160;
  localparam int EX_MEM_W = 104;
  localparam int MEM_WB_W = 72;

  localparam logic [IF_ID_W-1:0]  IF_ID_FLUSH  = '0;
  localparam logic [ID_EX_W-1:0]  ID_EX_FLUSH  = '0;
  localparam logic [EX_MEM_W-1:0] EX_MEM_FLUSH = '0;
  localparam logic [MEM_WB_W-1:0] MEM_WB_FLUSH = '0;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with a 0..2 increment.
// Sticks at all-ones once reached.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W:0] sum;

  assign sum = {1'b0, cnt} + (CNT_W+1)'(inc);

  always_ff @(posedge clk) begin
    if (clear)
      cnt <= '0;
    else if (sum[CNT_W])
      cnt <= '1;
    else
      cnt <= sum[CNT_W-1:0];
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Stage register with 2-entry skid, freeze/flush and
// a saturating count of entries discarded by flush.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = IF_ID_W,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
  parameter int                CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  drop_cnt
);

  logic              m_valid;
  logic              s_valid;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] s_data;
  logic              acc;
  logic              fire;
  logic [1:0]        drop_inc;

  assign in_ready  = ~s_valid & ~freeze & ~flush;
  assign out_valid = m_valid & ~freeze;
  assign out_data  = m_data;
  assign occupancy = 2'(m_valid) + 2'(s_valid);
  assign acc       = in_valid & in_ready;
  assign fire      = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= FLUSH_VAL;
      s_data  <= FLUSH_VAL;
    end else if (!freeze) begin
      if (!m_valid || fire) begin
        if (s_valid) begin
          m_valid <= 1'b1;
          m_data  <= s_data;
          if (acc)
            s_data <= in_data;
          else
            s_valid <= 1'b0;
        end else if (acc) begin
          m_valid <= 1'b1;
          m_data  <= in_data;
        end else begin
          m_valid <= 1'b0;
        end
      end else if (acc) begin
        // main is stalled downstream: park the beat
        s_valid <= 1'b1;
        s_data  <= in_data;
      end
    end
  end

  assign drop_inc = flush ? occupancy : 2'd0;

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_drop_cnt (
    .clk  (clk),
    .clear(rst),
    .inc  (drop_inc),
    .cnt  (drop_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a FIFO model
// predicts handshakes, occupancy, data and drop count.
module tb_pipe_stage_reg;

  localparam int DW = 16;
  localparam int CW = 3;
  localparam logic [DW-1:0] FV = 16'hDEAD;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          freeze;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic [1:0]    occupancy;
  logic [CW-1:0] drop_cnt;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] q[$];
  int  mdrop = 0;
  bit  cleared = 1'b1;
  bit  took;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W(DW),
    .FLUSH_VAL(FV),
    .CNT_W(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .freeze   (freeze),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .occupancy(occupancy),
    .drop_cnt (drop_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit iv, input logic [DW-1:0] d,
                       input bit ordy, input bit frz,
                       input bit fl, input bit rs,
                       output bit acc);
    bit eir;
    bit eov;
    int n;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    freeze    = frz;
    flush     = fl;
    rst       = rs;
    #1;
    n   = q.size();
    eir = (n < 2) && !frz && !fl;
    eov = (n > 0) && !frz;
    check("in_ready", 32'(in_ready), 32'(eir));
    check("out_valid", 32'(out_valid), 32'(eov));
    check("occupancy", 32'(occupancy), 32'(n));
    check("drop_cnt", 32'(drop_cnt), 32'(mdrop));
    if (n > 0)
      check("out_data", 32'(out_data), 32'(q[0]));
    else if (cleared)
      check("flush_data", 32'(out_data), 32'(FV));
    acc = 1'b0;
    @(posedge clk);
    if (rs) begin
      q.delete();
      mdrop = 0;
      cleared = 1'b1;
    end else if (fl) begin
      mdrop = mdrop + n;
      if (mdrop > CMAX) mdrop = CMAX;
      q.delete();
      cleared = 1'b1;
    end else if (!frz) begin
      if (eov && ordy) void'(q.pop_front());
      if (iv && eir) begin
        q.push_back(d);
        acc = 1'b1;
        cleared = 1'b0;
      end
    end
  endtask

  task automatic idle(input bit ordy);
    cycle(1'b0, '0, ordy, 1'b0, 1'b0, 1'b0, took);
  endtask

  task automatic push(input logic [DW-1:0] d, input bit ordy);
    cycle(1'b1, d, ordy, 1'b0, 1'b0, 1'b0, took);
  endtask

  task automatic fill2(input logic [DW-1:0] base);
    push(base, 1'b0);
    push(base + 1, 1'b0);
  endtask

  task automatic do_flush();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, took);
  endtask

  initial begin
    rst = 1'b1;
    freeze = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);

    // reset state
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, took);
    idle(1'b0);

    // streaming
    push(16'h1, 1'b1);
    push(16'h2, 1'b1);
    push(16'h3, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // backpressure
    push(16'hA, 1'b0);
    push(16'hB, 1'b0);
    push(16'hC, 1'b0);
    push(16'hC, 1'b0);
    took = 1'b0;
    for (int i = 0; i < 8 && !took; i++)
      push(16'hC, 1'b1);
    check("c_accepted", 32'(took), 32'd1);
    repeat (4) idle(1'b1);

    // flush with two entries
    fill2(16'h20);
    do_flush();
    idle(1'b0);

    // freeze holds 0x55
    push(16'h55, 1'b0);
    repeat (3)
      cycle(1'b1, 16'h66, 1'b1, 1'b1, 1'b0, 1'b0, took);
    idle(1'b1);
    idle(1'b1);

    // flush while frozen with input offered
    push(16'h77, 1'b0);
    cycle(1'b1, 16'h78, 1'b1, 1'b1, 1'b1, 1'b0, took);
    check("ff_no_acc", 32'(took), 32'd0);
    idle(1'b1);

    // reset mid-stream with drop_cnt=5
    fill2(16'h30);
    do_flush();
    fill2(16'h40);
    check("pre_rst_drop", 32'(mdrop), 32'd5);
    cycle(1'b1, 16'h50, 1'b0, 1'b0, 1'b0, 1'b1, took);
    idle(1'b0);

    // saturation
    for (int k = 0; k < 4; k++) begin
      fill2(16'h100 + 16'(k * 2));
      do_flush();
    end
    push(16'h200, 1'b0);
    do_flush();
    idle(1'b0);
    check("sat_model", 32'(mdrop), 32'(CMAX));

    // random mix
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom),
            1'($urandom_range(0, 1)),
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 99) == 0, took);
    end
    repeat (3) idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
